if_prefetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline buffer. It owns the program counter and drives the combinational instruction memory address. It stores fetched {PC+4, instruction} pairs in a small first-word-fall-through queue, which decouples fetch from decode stalls. Taken branches resolved in MEM redirect it, and it flushes its queue on redirect.

---
 rtl/if_prefetch_queue.sv | 114 +++++++++++
 tb/tb_if_prefetch_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch front end with a small first-word-fall-through queue
//   that sits in front of the IF/ID buffer. It owns the PC, drives the
//   combinational instruction-memory address, and buffers {PC+4, instr}
//   pairs. This lets fetch keep running while decode is stalled.
//   A taken branch from MEM redirects the PC and flushes the queue.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   redirect      taken-branch strobe from MEM
//   redirect_pc   branch target (bits [1:0] ignored)
//   imem_addr     word-aligned fetch address (driven from the PC register)
//   imem_data     instruction word for imem_addr, same cycle
//   out_ready     decode accepts the head entry this cycle
//   out_valid     head entry is valid
//   out_npc       PC+4 of the head instruction (0 when empty)
//   out_instr     head instruction word (0 / nop when empty)
//   count         number of occupied queue entries
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_npc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   npc_mem_q   [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          push, pop;
  logic [31:0]   pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;   // wraps modulo 2^32
  assign imem_addr = {pc_q[31:2], 2'b00};

  assign out_valid = (cnt_q != '0);
  assign out_npc   = out_valid ? npc_mem_q[head_q]   : 32'h0;
  assign out_instr = out_valid ? instr_mem_q[head_q] : 32'h0;
  assign count     = cnt_q;

  // Gating with out_valid means out_ready is ignored when the queue is empty.
  assign pop  = out_valid & out_ready;
  // A full queue can still take a new word in a cycle that also drains one.
  assign push = !redirect & ((cnt_q < CW'(DEPTH)) | pop);

  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (redirect) begin
      // A same-cycle pop has already been consumed by decode, so the entire
      // queue is dropped. Fetch restarts from the target on the next edge.
      pc_d   = {redirect_pc[31:2], 2'b00};
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_plus4;
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // The data storage needs no reset. Entries are only visible through
  // out_* when cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      npc_mem_q[tail_q]   <= pc_plus4;
      instr_mem_q[tail_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_npc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory model: each word holds its own address.
  assign imem_data = imem_addr;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_npc(out_npc), .out_instr(out_instr),
    .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    step(); step();
    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_npc",   out_npc,   32'h0);
    chk("rst_addr",  imem_addr, 32'h0);

    // 1: streaming with out_ready=1
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_npc",   out_npc,   32'(4 * (i + 1)));
      chk("t1_instr", out_instr, 32'(4 * i));
      chk("t1_count", 32'(count), 32'd1);
    end

    // 2: fill with out_ready=0
    rst = 1'b1; step(); rst = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_count", 32'(count), 32'(i));
    end
    step(); step();
    chk("t2_count_hold", 32'(count), 32'd4);
    chk("t2_addr",  imem_addr, 32'd16);
    chk("t2_instr", out_instr, 32'd0);
    chk("t2_npc",   out_npc,   32'd4);

    // 3: full queue, one pop with a simultaneous push
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t3_npc",   out_npc,   32'd8);
    chk("t3_instr", out_instr, 32'd4);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_addr",  imem_addr, 32'd20);

    // 4: redirect while holding 3 entries
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    chk("t4_pre_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h43; step(); redirect = 1'b0;
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_addr",  imem_addr, 32'h40);
    step();
    chk("t4_valid2", 32'(out_valid), 32'd1);
    chk("t4_npc",    out_npc,   32'h44);
    chk("t4_instr",  out_instr, 32'h40);
    chk("t4_count2", 32'(count), 32'd1);

    // 5: reset wins over a simultaneous redirect
    out_ready = 1'b1; step(); step();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h100; step();
    rst = 1'b0; redirect = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_addr",  imem_addr, 32'h0);

    // 6: redirect to the top word with out_ready=1, PC wraps
    step();
    chk("t6_pre_count", 32'(count), 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); redirect = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_addr",  imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_npc",   out_npc,   32'h0);
    chk("t6_instr", out_instr, 32'hFFFF_FFFC);
    chk("t6_addr2", imem_addr, 32'h0);
    step();
    chk("t6_npc2",   out_npc,   32'h4);
    chk("t6_instr2", out_instr, 32'h0);
    chk("t6_addr3",  imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
